// File: rtl/regfile_wsel_scoreboard_if.sv
// Bus bundle for the register-file write-select decoder and busy scoreboard.
// busy_cnt exists only when BUSY_COUNT_EN is defined.
interface regfile_wsel_scoreboard_if #(
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [NREG-1:0]   wsel_n;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_dst;
  logic              iss_dst_v;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              flush;
  logic              stall;
  logic [NREG-1:0]   busy;
`ifdef BUSY_COUNT_EN
  logic [ADDR_W:0]   busy_cnt;
`endif

  modport master (
`ifdef BUSY_COUNT_EN
    input  busy_cnt,
`endif
    output wb_en, wb_addr, iss_en, iss_dst, iss_dst_v, rs_addr, rt_addr, flush,
    input  wsel_n, stall, busy
  );

  modport slave (
`ifdef BUSY_COUNT_EN
    output busy_cnt,
`endif
    input  wb_en, wb_addr, iss_en, iss_dst, iss_dst_v, rs_addr, rt_addr, flush,
    output wsel_n, stall, busy
  );
endinterface

// File: rtl/regfile_wsel_scoreboard.sv
// Registered active-low one-hot write-select decoder plus per-register busy scoreboard
// with issue stall. Define BUSY_COUNT_EN to add the registered busy_cnt population count.
module regfile_wsel_scoreboard #(
  parameter int unsigned ADDR_W         = 5,
  parameter bit          ZERO_REG_FIXED = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  regfile_wsel_scoreboard_if.slave      bus
);
  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [NREG-1:0] wsel_n_q, wsel_n_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy_eff;
  logic            stall_c;
  logic            accept;

  // Writeback one-hot, same-cycle bypass into hazard view, and next scoreboard state.
  always_comb begin
    wb_mask  = '0;
    busy_eff = '0;
    stall_c  = 1'b0;
    accept   = 1'b0;
    wsel_n_d = '1;
    busy_d   = busy_q;

    if (bus.wb_en) wb_mask[bus.wb_addr] = 1'b1;
    if (ZERO_REG_FIXED) wb_mask[0] = 1'b0;

    busy_eff = busy_q & ~wb_mask;
    if (ZERO_REG_FIXED) busy_eff[0] = 1'b0;

    stall_c = bus.iss_en & (busy_eff[bus.rs_addr] | busy_eff[bus.rt_addr] |
                            (bus.iss_dst_v & busy_eff[bus.iss_dst]));
    accept  = bus.iss_en & ~stall_c & ~bus.flush;

    wsel_n_d = ~wb_mask;

    // Flush discards everything; otherwise set after clear so a re-issue wins.
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~wb_mask;
      if (accept && bus.iss_dst_v) busy_d[bus.iss_dst] = 1'b1;
    end
    if (ZERO_REG_FIXED) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel_n_q <= '1;
      busy_q   <= '0;
    end else begin
      wsel_n_q <= wsel_n_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.wsel_n = wsel_n_q;
  assign bus.busy   = busy_q;
  assign bus.stall  = stall_c;

`ifdef BUSY_COUNT_EN
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt_q <= '0;
    else        busy_cnt_q <= busy_cnt_d;
  end

  assign bus.busy_cnt = busy_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wsel_scoreboard.sv
// Directed self-checking bench: a 5-bit-address instance for decode/scoreboard
// behaviour and a 3-bit-address instance for parametrisation (and busy_cnt when enabled).
module tb_regfile_wsel_scoreboard;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  regfile_wsel_scoreboard_if #(.ADDR_W(5)) b5 ();
  regfile_wsel_scoreboard_if #(.ADDR_W(3)) b3 ();

  regfile_wsel_scoreboard #(.ADDR_W(5), .ZERO_REG_FIXED(1'b1)) u5 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b5)
  );

  regfile_wsel_scoreboard #(.ADDR_W(3), .ZERO_REG_FIXED(1'b1)) u3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle5();
    b5.wb_en = 1'b0; b5.wb_addr = '0; b5.iss_en = 1'b0; b5.iss_dst = '0;
    b5.iss_dst_v = 1'b0; b5.rs_addr = '0; b5.rt_addr = '0; b5.flush = 1'b0;
  endtask

  task automatic idle3();
    b3.wb_en = 1'b0; b3.wb_addr = '0; b3.iss_en = 1'b0; b3.iss_dst = '0;
    b3.iss_dst_v = 1'b0; b3.rs_addr = '0; b3.rt_addr = '0; b3.flush = 1'b0;
  endtask

  task automatic issue5(input logic [4:0] dst);
    b5.iss_en = 1'b1; b5.iss_dst = dst; b5.iss_dst_v = 1'b1;
    b5.rs_addr = '0; b5.rt_addr = '0;
  endtask

  initial begin
    logic [31:0] exp_w;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle5();
    idle3();
    #12;
    check("rst_wsel_n", b5.wsel_n, 32'hFFFF_FFFF);
    check("rst_busy",   b5.busy,   32'h0);
    rst_n = 1'b1;
    step();

    // Decode sweep: register 0 never selected.
    b5.wb_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      b5.wb_addr = 5'(a);
      step();
      exp_w = (a == 0) ? 32'hFFFF_FFFF : ~(32'h1 << a);
      check($sformatf("decode_%0d", a), b5.wsel_n, exp_w);
    end
    b5.wb_en = 1'b0;
    step();
    check("decode_idle",   b5.wsel_n, 32'hFFFF_FFFF);
    check("wb_nonbusy",    b5.busy,   32'h0);

    // RAW hazard and same-cycle writeback bypass.
    issue5(5'd5);
    #1 check("raw_first_stall", 32'(b5.stall), 32'h0);
    step();
    check("raw_busy5", b5.busy, 32'h0000_0020);
    b5.iss_dst_v = 1'b0; b5.iss_dst = '0; b5.rs_addr = 5'd5;
    #1 check("raw_stall", 32'(b5.stall), 32'h1);
    b5.wb_en = 1'b1; b5.wb_addr = 5'd5;
    #1 check("raw_bypass_stall", 32'(b5.stall), 32'h0);
    step();
    check("raw_cleared",   b5.busy,   32'h0);
    check("raw_wsel_n",    b5.wsel_n, 32'hFFFF_FFDF);
    idle5();

    // WAW hazard, stalled issue must not change state.
    issue5(5'd9);
    step();
    check("waw_busy9", b5.busy, 32'h0000_0200);
    #1 check("waw_stall", 32'(b5.stall), 32'h1);
    step();
    check("waw_held", b5.busy, 32'h0000_0200);

    // Set-over-clear on register 7.
    issue5(5'd7);
    step();
    check("soc_pre", b5.busy, 32'h0000_0280);
    b5.wb_en = 1'b1; b5.wb_addr = 5'd7;
    #1 check("soc_stall", 32'(b5.stall), 32'h0);
    step();
    check("soc_busy",   b5.busy,   32'h0000_0280);
    check("soc_wsel_n", b5.wsel_n, 32'hFFFF_FF7F);
    idle5();

    // Flush clears everything, ignores issue, but writeback still decodes.
    b5.flush = 1'b1;
    step();
    check("flush_clear", b5.busy, 32'h0);
    idle5();
    issue5(5'd10);
    step();
    issue5(5'd11);
    step();
    check("flush_pre", b5.busy, 32'h0000_0C00);
    issue5(5'd3);
    b5.flush = 1'b1; b5.wb_en = 1'b1; b5.wb_addr = 5'd10;
    step();
    check("flush_busy",   b5.busy,   32'h0);
    check("flush_wsel_n", b5.wsel_n, 32'hFFFF_FBFF);
    idle5();

    // Register 0 never becomes busy nor stalls.
    issue5(5'd0);
    step();
    check("zero_busy", b5.busy, 32'h0);
    #1 check("zero_stall", 32'(b5.stall), 32'h0);
    idle5();

    // Asynchronous reset mid-run with pending marks and a live write select.
    b5.wb_en = 1'b1; b5.wb_addr = 5'd3;
    for (int d = 4; d < 8; d++) begin
      issue5(5'(d));
      step();
    end
    check("mrst_pre_busy", b5.busy,   32'h0000_00F0);
    check("mrst_pre_wsel", b5.wsel_n, 32'hFFFF_FFF7);
    idle5();
    b5.iss_en = 1'b1; b5.rs_addr = 5'd4;
    #1 check("mrst_pre_stall", 32'(b5.stall), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mrst_wsel_n", b5.wsel_n,        32'hFFFF_FFFF);
    check("mrst_busy",   b5.busy,          32'h0);
    check("mrst_stall",  32'(b5.stall),    32'h0);
    #3 rst_n = 1'b1;
    b5.iss_en = 1'b0;
    step();
    check("mrst_hold_wsel", b5.wsel_n, 32'hFFFF_FFFF);
    check("mrst_hold_busy", b5.busy,   32'h0);

    // Narrow instance: 8-bit select and scoreboard.
    for (int d = 1; d < 5; d++) begin
      b3.iss_en = 1'b1; b3.iss_dst_v = 1'b1;
      b3.iss_dst = (d == 4) ? 3'd0 : 3'(d);
      step();
      check($sformatf("n3_busy_%0d", d), 32'(b3.busy),
            (d == 1) ? 32'h02 : (d == 2) ? 32'h06 : 32'h0E);
`ifdef BUSY_COUNT_EN
      check($sformatf("n3_cnt_%0d", d), 32'(b3.busy_cnt), (d == 4) ? 32'd3 : 32'(d));
`endif
    end
    idle3();
    b3.wb_en = 1'b1; b3.wb_addr = 3'd6;
    step();
    check("n3_wsel_n", 32'(b3.wsel_n), 32'h0000_00BF);
    check("n3_busy_wb_nonbusy", 32'(b3.busy), 32'h0E);
    b3.wb_en = 1'b1; b3.wb_addr = 3'd2;
    step();
    check("n3_busy_clr2", 32'(b3.busy), 32'h0A);
`ifdef BUSY_COUNT_EN
    check("n3_cnt_clr2", 32'(b3.busy_cnt), 32'd2);
`endif
    idle3();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wsel_scoreboard.md
Name: regfile_wsel_scoreboard

Overview:
- Parametrised successor to the fixed 5-to-32 active-low register-select decoder.
- Registered N-to-2^N active-low one-hot write-select decoder for the register file write port.
- Adds a per-register busy scoreboard: set at issue, cleared at writeback, producing an issue stall for RAW/WAW hazards.
- Sits between decode/issue and writeback stages of the pipeline.

Parameters:
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W (derived localparam).
- ZERO_REG_FIXED, 1, when 1 register 0 is hardwired: never selected for write, never busy, never causes stall.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wb_en  input  1  writeback valid this cycle.
- wb_addr  input  ADDR_W  writeback destination register.
- wsel_n  output  NREG  registered active-low one-hot write select (bit i low = write register i).
- iss_en  input  1  instruction requesting issue this cycle.
- iss_dst  input  ADDR_W  destination register of issuing instruction.
- iss_dst_v  input  1  issuing instruction writes a register.
- rs_addr  input  ADDR_W  source operand 1.
- rt_addr  input  ADDR_W  source operand 2.
- flush  input  1  pipeline flush; discards all pending busy marks.
- stall  output  1  combinational; issue blocked this cycle.
- busy  output  NREG  registered scoreboard state, bit i = register i has a pending write.

Behaviour:
- Reset (rst_n low, asynchronous): wsel_n = all ones; busy = all zeros; stall follows combinationally from the cleared state.
- wsel_n: one-cycle latency. At edge with wb_en=1, wsel_n <= ~(1 << wb_addr); otherwise all ones. If ZERO_REG_FIXED and wb_addr==0, all ones. At most one bit low at any time.
- Effective busy for hazard checks: busy_eff = busy with bit wb_addr cleared when wb_en=1 (same-cycle writeback bypass).
- stall = iss_en & (busy_eff[rs_addr] | busy_eff[rt_addr] | (iss_dst_v & busy_eff[iss_dst])); register-0 terms masked when ZERO_REG_FIXED.
- Issue accepted when iss_en & ~stall & ~flush.
- busy update per edge, priority order:
  1. flush: busy <= 0. Issue is ignored; the writeback still drives wsel_n.
  2. Otherwise clear bit wb_addr if wb_en.
  3. Then set bit iss_dst if issue accepted and iss_dst_v.
- Same address cleared and set in one cycle: set wins, bit ends at 1.
- Writeback to a non-busy register is legal: wsel_n is generated, busy is unchanged.
- Width rules: all address comparisons use the full ADDR_W; no out-of-range addresses exist.

Optional Feature:
- Macro BUSY_COUNT_EN.
- Defined: adds output busy_cnt [ADDR_W:0], a registered population count of busy, updated on the same edge as busy. Reset value 0; range 0..NREG (0..NREG-1 when ZERO_REG_FIXED).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-run with busy=0x0000_00F0 -> immediately wsel_n=0xFFFF_FFFF, busy=0, stall=0 (iss_en=1); all hold after release.
- Decode sweep (ADDR_W=5): wb_en=1, wb_addr=0..31 on consecutive cycles -> one cycle later wsel_n = ~(1<<a) for a=1..31; a=0 gives 0xFFFF_FFFF (ZERO_REG_FIXED=1). wb_en=0 -> all ones.
- RAW stall: issue dst=5 accepted -> busy[5]=1. Next cycle iss_en=1, rs=5 -> stall=1. wb_en=1, wb_addr=5 same cycle -> stall=0 and busy[5]=0 next cycle unless re-issued.
- Set-over-clear: busy[7]=1; same cycle wb_addr=7 and accepted issue dst=7 -> busy[7]=1 after edge; wsel_n=0xFFFF_FF7F.
- Flush: busy=0x0000_0C00, flush=1, iss_en=1, dst=3, wb_en=1, wb_addr=10 -> busy=0 next cycle; wsel_n=0xFFFF_FBFF.
- Parametrisation/feature: ADDR_W=3 with BUSY_COUNT_EN; issue dst 1,2,3 -> busy_cnt 1,2,3. Register-0 issue leaves busy_cnt unchanged; wsel_n is 8 bits wide.
